// File: rtl/uvmt_apb_st_dut_bridge_pkg.sv
// Package uvmt_apb_st_dut_pkg: shared types and constants for the APB
// self-test bridge.
//   - uvmt_apb_st_dut_bridge_state_enum : bridge FSM states
//   - DEFAULT_* : default parameter values used by the bridge and interface
//   - PPROT_WIDTH : width of the APB protection field
package uvmt_apb_st_dut_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int PPROT_WIDTH            = 3;

  // IDLE is encoded as zero so the debug state output resets to 0.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } uvmt_apb_st_dut_bridge_state_enum;

endpackage

// File: rtl/uvmt_apb_st_dut_bridge_if.sv
// APB bus bundle used on both sides of the bridge.
// Handshake: a transfer starts with psel=1/penable=0 (SETUP) for one cycle,
// then psel=1/penable=1 (ACCESS) with all request fields held stable until
// the completer answers with pready=1; prdata/pslverr are only meaningful
// in that pready cycle.
//   modport master : requester side (drives request, samples response)
//   modport slave  : completer side (samples request, drives response)
interface uvmt_apb_st_dut_bridge_if #(
  parameter int ADDR_WIDTH = uvmt_apb_st_dut_pkg::DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = uvmt_apb_st_dut_pkg::DEFAULT_DATA_WIDTH
);
  logic                                      psel;
  logic                                      penable;
  logic                                      pwrite;
  logic [ADDR_WIDTH-1:0]                     paddr;
  logic [DATA_WIDTH-1:0]                     pwdata;
  logic [DATA_WIDTH/8-1:0]                   pstrb;
  logic [uvmt_apb_st_dut_pkg::PPROT_WIDTH-1:0] pprot;
  logic [DATA_WIDTH-1:0]                     prdata;
  logic                                      pready;
  logic                                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uvmt_apb_st_dut_timeout_cntr.sv
// Downstream ACCESS-phase watchdog counter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (asserted in the cycle before ACCESS)
//   enable     : count this cycle (asserted in every ACCESS cycle)
//   expired    : current ACCESS cycle is the last one allowed
module uvmt_apb_st_dut_timeout_cntr #(
  parameter int TIMEOUT_CYCLES = uvmt_apb_st_dut_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uvmt_apb_st_dut_timeout_cntr: TIMEOUT_CYCLES must be >= 1");
  end

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  // The count holds the number of ACCESS cycles already completed, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the final permitted one.
  assign expired = enable && (count_q >= LAST);

endmodule

// File: rtl/uvmt_apb_st_dut_bridge.sv
// Single-slot APB-to-APB register bridge.
// Captures one upstream transfer, replays it downstream as SETUP/ACCESS,
// then returns the downstream response upstream for exactly one cycle.
// A watchdog aborts a downstream ACCESS that never sees pready.
//   clk, reset : clock, asynchronous active-high reset
//   mstr_if    : upstream completer port (master agent side)
//   slv_if     : downstream requester port (slave agent side)
//   timeout    : one-cycle pulse (in the RESP cycle) for every abort
//   dbg_state  : current FSM state
module uvmt_apb_st_dut_bridge
  import uvmt_apb_st_dut_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  uvmt_apb_st_dut_bridge_if.slave          mstr_if,
  uvmt_apb_st_dut_bridge_if.master         slv_if,
  output logic                             timeout,
  output uvmt_apb_st_dut_bridge_state_enum dbg_state
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_data_width
    $error("uvmt_apb_st_dut_bridge: DATA_WIDTH must be 8, 16 or 32");
  end

  uvmt_apb_st_dut_bridge_state_enum state_q, state_d;
  logic                   capture;
  logic                   expired;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   write_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_WIDTH-1:0]  strb_q;
  logic [PPROT_WIDTH-1:0] prot_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   slverr_q;
  logic                   timeout_q;

  uvmt_apb_st_dut_timeout_cntr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cntr (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_SETUP),
    .enable (state_q == ST_ACCESS),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only a SETUP phase in IDLE starts a transfer; an upstream ACCESS phase
  // seen in IDLE is the tail of the transfer just answered, or stray.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mstr_if.psel && !mstr_if.penable) begin
          capture = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (slv_if.pready || expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are sampled once at capture and never again, so an
  // upstream that changes them mid-transfer cannot corrupt the replay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (capture) begin
        addr_q  <= mstr_if.paddr;
        write_q <= mstr_if.pwrite;
        wdata_q <= mstr_if.pwdata;
        strb_q  <= mstr_if.pstrb;
        prot_q  <= mstr_if.pprot;
      end
      if (state_q == ST_ACCESS) begin
        // A real pready beats a simultaneous expiry.
        if (slv_if.pready) begin
          rdata_q  <= write_q ? '0 : slv_if.prdata;
          slverr_q <= slv_if.pslverr;
        end else if (expired) begin
          rdata_q   <= '0;
          slverr_q  <= 1'b1;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  // Control outputs decode directly from the state register so that an
  // asynchronous reset drops both buses immediately.
  assign slv_if.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign slv_if.penable = (state_q == ST_ACCESS);
  assign slv_if.pwrite  = write_q;
  assign slv_if.paddr   = addr_q;
  assign slv_if.pwdata  = wdata_q;
  assign slv_if.pstrb   = strb_q;
  assign slv_if.pprot   = prot_q;

  assign mstr_if.pready  = (state_q == ST_RESP);
  assign mstr_if.pslverr = (state_q == ST_RESP) && slverr_q;
  assign mstr_if.prdata  = (state_q == ST_RESP) ? rdata_q : '0;

  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uvmt_apb_st_dut_bridge.sv
module tb_uvmt_apb_st_dut_bridge;
  import uvmt_apb_st_dut_pkg::*;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic timeout;
  uvmt_apb_st_dut_bridge_state_enum dbg_state;
  int cyc_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  uvmt_apb_st_dut_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mstr_if ();
  uvmt_apb_st_dut_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) slv_if ();

  uvmt_apb_st_dut_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mstr_if  (mstr_if),
    .slv_if   (slv_if),
    .timeout  (timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- vectors and reference model ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          hang;
    logic [31:0] rdata;
    bit          slverr;
    int          exp_lat;
    logic [31:0] exp_prdata;
    bit          exp_slverr;
    int          exp_to;
  } vec_t;

  vec_t tbl[8];

  int n_tests;
  int n_fail;
  int last_resp_cyc;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] strb, logic [2:0] prot, int waits,
                              bit hang, logic [31:0] rdata, bit slverr,
                              int exp_lat, logic [31:0] exp_prdata,
                              bit exp_slverr, int exp_to);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.waits = waits; v.hang = hang; v.rdata = rdata; v.slverr = slverr;
    v.exp_lat = exp_lat; v.exp_prdata = exp_prdata;
    v.exp_slverr = exp_slverr; v.exp_to = exp_to;
    return v;
  endfunction

  // Upstream view of one transfer: two wait states plus one per downstream
  // wait, or a forced error after TO ACCESS cycles if the completer stalls.
  function automatic vec_t predict(vec_t v);
    bit aborted;
    aborted      = v.hang || (v.waits >= TO);
    v.exp_lat    = aborted ? TO + 2 : v.waits + 3;
    v.exp_prdata = (aborted || v.wr) ? 32'h0 : v.rdata;
    v.exp_slverr = aborted ? 1'b1 : v.slverr;
    v.exp_to     = aborted ? 1 : 0;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_pready"},  64'(mstr_if.pready),  64'h0);
    check({tag, "_s_pslverr"}, 64'(mstr_if.pslverr), 64'h0);
    check({tag, "_s_prdata"},  64'(mstr_if.prdata),  64'h0);
    check({tag, "_m_psel"},    64'(slv_if.psel),     64'h0);
    check({tag, "_m_penable"}, 64'(slv_if.penable),  64'h0);
    check({tag, "_m_pwrite"},  64'(slv_if.pwrite),   64'h0);
    check({tag, "_m_paddr"},   64'(slv_if.paddr),    64'h0);
    check({tag, "_m_pwdata"},  64'(slv_if.pwdata),   64'h0);
    check({tag, "_m_pstrb"},   64'(slv_if.pstrb),    64'h0);
    check({tag, "_m_pprot"},   64'(slv_if.pprot),    64'h0);
    check({tag, "_timeout"},   64'(timeout),         64'h0);
    check({tag, "_state"},     64'(dbg_state),       64'(ST_IDLE));
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mstr_if.psel    = 1'b0;
      mstr_if.penable = 1'b0;
    end
  endtask

  // Runs one upstream transfer with the downstream responder acting per v,
  // then checks latency, response and the replayed downstream fields.
  task automatic do_xfer(input vec_t v, input bit mutate, input string tag);
    int          lat, to_cnt, n_set, n_acc, acc_idx, exp_acc;
    bit          done;
    logic [31:0] got_rd, seen_addr, seen_wdata;
    logic        got_err, seen_wr, psel_at_resp;
    logic [3:0]  seen_strb;
    logic [2:0]  seen_prot;
    lat = 0; to_cnt = 0; n_set = 0; n_acc = 0; acc_idx = 0; done = 0;
    got_rd = 32'h0; got_err = 1'b0; psel_at_resp = 1'b0;
    seen_addr = 32'h0; seen_wdata = 32'h0; seen_wr = 1'b0;
    seen_strb = 4'h0; seen_prot = 3'h0;

    @(posedge clk); #1;
    mstr_if.psel    = 1'b1;
    mstr_if.penable = 1'b0;
    mstr_if.pwrite  = v.wr;
    mstr_if.paddr   = v.addr;
    mstr_if.pwdata  = v.wdata;
    mstr_if.pstrb   = v.strb;
    mstr_if.pprot   = v.prot;
    slv_if.pready   = 1'b0;
    slv_if.prdata   = 32'h0;
    slv_if.pslverr  = 1'b0;

    for (int c = 0; c < 24 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mstr_if.penable = 1'b1;
        slv_if.pready   = 1'b0;
        slv_if.prdata   = 32'h0;
        slv_if.pslverr  = 1'b0;
        if (mutate && c >= 2) begin
          mstr_if.paddr  = $urandom;
          mstr_if.pwdata = $urandom;
          mstr_if.pstrb  = 4'($urandom_range(0, 15));
          mstr_if.pprot  = 3'($urandom_range(0, 7));
          mstr_if.pwrite = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      if (timeout) to_cnt++;
      if (slv_if.psel) begin
        seen_addr  = slv_if.paddr;
        seen_wdata = slv_if.pwdata;
        seen_strb  = slv_if.pstrb;
        seen_prot  = slv_if.pprot;
        seen_wr    = slv_if.pwrite;
        if (slv_if.penable) n_acc++;
        else n_set++;
      end
      if (mstr_if.pready) begin
        done          = 1;
        lat           = c;
        got_rd        = mstr_if.prdata;
        got_err       = mstr_if.pslverr;
        psel_at_resp  = slv_if.psel;
        last_resp_cyc = cyc_cnt;
      end else if (slv_if.psel && slv_if.penable) begin
        if (!v.hang && acc_idx == v.waits) begin
          slv_if.pready  = 1'b1;
          slv_if.prdata  = v.rdata;
          slv_if.pslverr = v.slverr;
        end
        acc_idx++;
      end
    end

    exp_acc = (v.exp_to != 0) ? TO : v.waits + 1;
    check({tag, "_latency"},     64'(lat),          64'(v.exp_lat));
    check({tag, "_s_prdata"},    64'(got_rd),       64'(v.exp_prdata));
    check({tag, "_s_pslverr"},   64'(got_err),      64'(v.exp_slverr));
    check({tag, "_timeout_cnt"}, 64'(to_cnt),       64'(v.exp_to));
    check({tag, "_setup_cyc"},   64'(n_set),        64'd1);
    check({tag, "_access_cyc"},  64'(n_acc),        64'(exp_acc));
    check({tag, "_m_psel_resp"}, 64'(psel_at_resp), 64'd0);
    check({tag, "_m_paddr"},     64'(seen_addr),    64'(v.addr));
    check({tag, "_m_pwdata"},    64'(seen_wdata),   64'(v.wdata));
    check({tag, "_m_pstrb"},     64'(seen_strb),    64'(v.strb));
    check({tag, "_m_pprot"},     64'(seen_prot),    64'(v.prot));
    check({tag, "_m_pwrite"},    64'(seen_wr),      64'(v.wr));
  endtask

  // ---------------- test ----------------
  initial begin
    int   prev;
    vec_t v;
    n_tests = 0; n_fail = 0; last_resp_cyc = 0; cyc_cnt = 0;

    tbl[0] = mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 32'h0,         0, 3, 32'h0,         0, 0);
    tbl[1] = mk(0, 32'h0000_0020, 32'h0,         4'h0, 3'd0, 3, 0, 32'h1234_5678, 0, 6, 32'h1234_5678, 0, 0);
    tbl[2] = mk(0, 32'h0000_0024, 32'h0,         4'h0, 3'd1, 1, 0, 32'hCAFE_F00D, 1, 4, 32'hCAFE_F00D, 1, 0);
    tbl[3] = mk(0, 32'h0000_0028, 32'h0,         4'h0, 3'd0, 0, 1, 32'h5555_AAAA, 0, 6, 32'h0,         1, 1);
    tbl[4] = mk(1, 32'h0000_002C, 32'h0BAD_F00D, 4'h3, 3'd4, 3, 0, 32'hFFFF_FFFF, 0, 6, 32'h0,         0, 0);
    tbl[5] = mk(1, 32'h0000_0030, 32'h1111_2222, 4'h5, 3'd7, 0, 0, 32'h0,         1, 3, 32'h0,         1, 0);
    tbl[6] = mk(0, 32'hFFFF_FFFC, 32'h0,         4'h0, 3'd2, 0, 0, 32'hA5A5_5A5A, 0, 3, 32'hA5A5_5A5A, 0, 0);
    tbl[7] = mk(1, 32'h8000_0000, 32'h7777_8888, 4'h8, 3'd3, 5, 0, 32'h0,         0, 6, 32'h0,         1, 1);

    reset = 1'b1;
    mstr_if.psel = 1'b0; mstr_if.penable = 1'b0; mstr_if.pwrite = 1'b0;
    mstr_if.paddr = 32'h0; mstr_if.pwdata = 32'h0; mstr_if.pstrb = 4'h0; mstr_if.pprot = 3'h0;
    slv_if.pready = 1'b0; slv_if.prdata = 32'h0; slv_if.pslverr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Upstream ACCESS phase without a SETUP phase must not start a transfer.
    @(posedge clk); #1;
    mstr_if.psel = 1'b1; mstr_if.penable = 1'b1; mstr_if.paddr = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_penable_m_psel", 64'(slv_if.psel), 64'd0);
      check("stray_penable_state",  64'(dbg_state),   64'(ST_IDLE));
    end
    idle(1);

    for (int i = 0; i < 8; i++) begin
      do_xfer(tbl[i], 1'b0, $sformatf("vec%0d", i));
      idle(1);
    end

    // Ten back-to-back writes: each setup lands in the cycle after RESP.
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      v = predict(mk(1, 32'h100 + 32'(i * 4), $urandom, 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 0, 0, 32'h0, 0, 0, 32'h0, 0, 0));
      do_xfer(v, 1'b0, $sformatf("b2b%0d", i));
      if (i > 0) check($sformatf("b2b%0d_period", i), 64'(last_resp_cyc - prev), 64'd4);
      prev = last_resp_cyc;
    end

    // Reset in the middle of a stalled downstream ACCESS.
    idle(1);
    @(posedge clk); #1;
    mstr_if.psel = 1'b1; mstr_if.penable = 1'b0; mstr_if.pwrite = 1'b1;
    mstr_if.paddr = 32'h40; mstr_if.pwdata = 32'hFACE_CAFE; mstr_if.pstrb = 4'hF; mstr_if.pprot = 3'd5;
    slv_if.pready = 1'b0;
    @(posedge clk); #1;
    mstr_if.penable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("mid_rst_pre_state", 64'(dbg_state), 64'(ST_ACCESS));
    reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    mstr_if.psel = 1'b0; mstr_if.penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_resp", 64'(mstr_if.pready), 64'd0);
    end
    do_xfer(tbl[1], 1'b0, "post_rst");

    // Randomized transfers against the reference model.
    for (int i = 0; i < 40; i++) begin
      v = predict(mk(1'($urandom_range(0, 1)), $urandom, $urandom,
                     4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     $urandom_range(0, 5), ($urandom_range(0, 7) == 0),
                     $urandom, 1'($urandom_range(0, 1)), 0, 32'h0, 0, 0));
      do_xfer(v, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uvmt_apb_st_dut_bridge.md
# uvmt_apb_st_dut_bridge

Single-slot APB-to-APB register bridge that forms the device-under-test of the APB self-test bench. The upstream completer port is driven by the master agent, and `mstr_if` connects there. The downstream requester port drives the slave agent, and `slv_if` connects there. The DUT checker observes both sides. Each upstream transfer is captured, replayed downstream as a full SETUP/ACCESS sequence, and its response returned upstream; a timeout guards against a hung completer.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `paddr` on both sides.
- `DATA_WIDTH`, 32: width of `pwdata`/`prdata`; legal values 8, 16, 32; any other value is an elaboration error.
- `TIMEOUT_CYCLES`, 256: maximum downstream ACCESS cycles before abort; legal range is ≥ 1.

Ports:
- `clk` in 1: sole clock; everything samples on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_psel`, `s_penable`, `s_pwrite` in 1 each: upstream control.
- `s_paddr` in `ADDR_WIDTH`: upstream address.
- `s_pwdata` in `DATA_WIDTH`: upstream write data.
- `s_pstrb` in `DATA_WIDTH/8`: upstream write strobes.
- `s_pprot` in 3: upstream protection.
- `s_prdata` out `DATA_WIDTH`: upstream read data.
- `s_pready`, `s_pslverr` out 1 each: upstream response.
- `m_psel`, `m_penable`, `m_pwrite` out 1 each: downstream control.
- `m_paddr`, `m_pwdata`, `m_pstrb`, `m_pprot` out: downstream copies, same widths as the upstream equivalents.
- `m_prdata` in `DATA_WIDTH`; `m_pready`, `m_pslverr` in 1 each: downstream response.
- `timeout` out 1: one-cycle pulse on every downstream abort.

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On `s_psel & ~s_penable`, capture `s_paddr`/`s_pwrite`/`s_pwdata`/`s_pstrb`/`s_pprot` into holding registers and go to SETUP.
  - `s_penable` seen without a preceding setup is ignored.
- SETUP: drive `m_psel`=1, `m_penable`=0 with the held fields; next state ACCESS unconditionally.
- ACCESS: drive `m_psel`=1, `m_penable`=1; the timeout counter increments each cycle.
  - `m_pready`=1: capture `m_prdata` (reads only; writes capture 0) and `m_pslverr`; go to RESP.
  - Counter reaches `TIMEOUT_CYCLES` with `m_pready` still 0: abort, capture `prdata`=0 and `pslverr`=1, pulse `timeout`, go to RESP.
- RESP: `s_pready`=1 for exactly one cycle; `s_prdata`/`s_pslverr` carry the captured values; next state IDLE.
- Outside RESP:
  - `s_pready`, `s_pslverr` = 0; `s_prdata` = 0.
  - `m_psel`/`m_penable` = 0 outside SETUP/ACCESS; `m_*` address, data and control fields hold their last value.
- Upstream fields are not re-sampled between capture and RESP. Changing them mid-transfer is an upstream protocol violation; the bridge keeps the captured values.
- Counter: width `$clog2(TIMEOUT_CYCLES+1)`, cleared on entry to ACCESS, saturates and never wraps.
- `m_pready` and timeout in the same cycle: `m_pready` wins and no timeout is raised.

## Timing
- Reset value of every output is 0, state is IDLE, counter is 0.
- Reset asserted mid-transfer: the bus drops immediately (asynchronously) and the in-flight transfer is discarded with no upstream response.
- Upstream setup at cycle T0 gives:
  - T1: `m_psel`=1.
  - T2: `m_penable`=1.
  - With zero downstream wait states, `m_pready` is seen at T2 and `s_pready`=1 at T3.
  - Upstream therefore sees 2 wait states plus one per downstream wait state.
- Back-to-back: a new upstream setup in the cycle after RESP is captured; the minimum transfer period is 4 cycles.
- A timeout abort leaves `m_psel`=0 in the cycle after the final ACCESS cycle.

## Structure
- Package `uvmt_apb_st_dut_pkg` holds:
  - the state enum `uvmt_apb_st_dut_bridge_state_enum`;
  - default parameter constants;
  - the `pprot` width constant (3).
- Sub-module `uvmt_apb_st_dut_timeout_cntr` holds the counter: inputs clear and enable; output expired; parameter `TIMEOUT_CYCLES`.

## Test plan
- Write to 0x0000_0010 with data 0xDEAD_BEEF, strobes 0xF, downstream 0 waits → downstream sees identical fields; `s_pready` rises 3 cycles after setup; `s_pslverr`=0.
- Read of 0x0000_0020 with downstream returning 0x1234_5678 after 3 waits → `s_prdata`=0x1234_5678 on the single `s_pready` cycle, 6 cycles after setup.
- Downstream `m_pslverr`=1 on a read → `s_pslverr`=1 and `s_prdata` = the returned data; no `timeout` pulse.
- `TIMEOUT_CYCLES`=4 with `m_pready` held 0 → `timeout` pulses once, `s_pslverr`=1, `s_prdata`=0; `m_psel` is low 1 cycle after the 4th ACCESS cycle.
- Ten back-to-back writes → period of 4 cycles each, all fields preserved, checker reports no error.
- `reset` asserted during downstream ACCESS → all outputs 0 asynchronously; after release, the next transfer completes normally.
